// File: rtl/muller_pipeline_pkg.sv
// muller_pipe_pkg: shared defaults and helpers for the Muller C-element pipeline.
//   MPIPE_WIDTH_DEF : default data width per token
//   MPIPE_DEPTH_DEF : default number of C-element stages
//   occ_width()     : width of the optional occupancy count (MULLER_PIPE_OCC_EN)
package muller_pipe_pkg;

    localparam int unsigned MPIPE_WIDTH_DEF = 8;
    localparam int unsigned MPIPE_DEPTH_DEF = 4;

    // A DEPTH-stage four-phase ring holds at most DEPTH/2 tokens.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth / 2 + 1);
    endfunction

endpackage

// File: rtl/muller_pipeline_c_element_sync.sv
// c_element_sync: clocked 2-input Muller C-element.
//   clk : clock, state updates on rising edge
//   rst : synchronous active-high reset (q -> 0)
//   a,b : C-element inputs
//   q   : registered C-element state
//   nxt : value q takes on the next edge when rst=0 (used by the parent
//         to detect 0->1 transitions and to precompute occupancy)
module c_element_sync (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic q,
    output logic nxt
);

    // Majority of (a, b, q): set when both high, clear when both low, else hold.
    always_comb begin
        nxt = (a & b) | (q & (a | b));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/muller_pipeline.sv
// muller_pipeline: synchronous model of a four-phase Muller C-element pipeline.
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset, discards all in-flight tokens
//   in_req    : four-phase request from producer
//   in_data   : producer data, WIDTH bits
//   in_ack    : four-phase acknowledge to producer (= c[0])
//   out_req   : four-phase request to consumer (= c[DEPTH-1])
//   out_data  : consumer data (= d[DEPTH-1])
//   out_ack   : four-phase acknowledge from consumer
//   occupancy : number of maximal runs of 1s in c[] (only when the macro
//               MULLER_PIPE_OCC_EN is defined)
// Parameters: WIDTH >= 1, DEPTH even and >= 2.
module muller_pipeline
    import muller_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = MPIPE_WIDTH_DEF,
    parameter int unsigned DEPTH = MPIPE_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_req,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ack,
    output logic             out_req,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ack
`ifdef MULLER_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    if (DEPTH < 2 || (DEPTH % 2) != 0) begin : g_bad_depth
        $error("muller_pipeline: DEPTH must be even and at least 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("muller_pipeline: WIDTH must be at least 1");
    end

    logic [DEPTH-1:0] c;
    logic [DEPTH-1:0] c_nxt;
    logic [DEPTH-1:0] rise;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] d_src [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic a_in;
        logic b_in;

        if (i == 0) begin : g_first
            assign a_in     = in_req;
            assign d_src[i] = in_data;
        end else begin : g_mid_a
            assign a_in     = c[i-1];
            assign d_src[i] = d[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign b_in = ~out_ack;
        end else begin : g_mid_b
            assign b_in = ~c[i+1];
        end

        c_element_sync u_cel (
            .clk (clk),
            .rst (rst),
            .a   (a_in),
            .b   (b_in),
            .q   (c[i]),
            .nxt (c_nxt[i])
        );
    end

    // A stage captures its upstream data exactly on its 0->1 control edge;
    // upstream data is guaranteed stable then because the upstream stage
    // cannot re-fire until this stage has gone high.
    assign rise = c_nxt & ~c;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rise[i]) begin
                    d[i] <= d_src[i];
                end
            end
        end
    end

    assign in_ack   = c[0];
    assign out_req  = c[DEPTH-1];
    assign out_data = d[DEPTH-1];

`ifdef MULLER_PIPE_OCC_EN
    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] occ_nxt;
    logic [OCC_W-1:0] occ_q;

    // Counted from the next-state vector so the registered count lines up
    // with c[] on the same edge.
    always_comb begin
        logic prev;
        occ_nxt = '0;
        prev    = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (c_nxt[i] && !prev) begin
                occ_nxt = occ_nxt + OCC_W'(1);
            end
            prev = c_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_nxt;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_muller_pipeline.sv
// Self-checking bench for muller_pipeline: directed four-phase scenarios on
// a default (WIDTH=8, DEPTH=4) instance and a randomized producer/consumer
// run with a FIFO scoreboard on a WIDTH=16, DEPTH=6 instance.
module tb_muller_pipeline;
    import muller_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default instance
    logic        in_req_a  = 1'b0;
    logic [7:0]  in_data_a = '0;
    logic        in_ack_a;
    logic        out_req_a;
    logic [7:0]  out_data_a;
    logic        out_ack_a;
    logic        ack_tie   = 1'b0;
    logic        ack_drv   = 1'b0;
    assign out_ack_a = ack_tie ? out_req_a : ack_drv;

    // Random-run instance
    logic        in_req_b   = 1'b0;
    logic [15:0] in_data_b  = '0;
    logic        in_ack_b;
    logic        out_req_b;
    logic [15:0] out_data_b;
    logic        out_ack_b  = 1'b0;

`ifdef MULLER_PIPE_OCC_EN
    logic [occ_width(4)-1:0] occ_a;
    logic [occ_width(6)-1:0] occ_b;
`endif

    muller_pipeline dut_a (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req_a),
        .in_data  (in_data_a),
        .in_ack   (in_ack_a),
        .out_req  (out_req_a),
        .out_data (out_data_a),
        .out_ack  (out_ack_a)
`ifdef MULLER_PIPE_OCC_EN
        ,
        .occupancy(occ_a)
`endif
    );

    muller_pipeline #(.WIDTH(16), .DEPTH(6)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req_b),
        .in_data  (in_data_b),
        .in_ack   (in_ack_b),
        .out_req  (out_req_b),
        .out_data (out_data_b),
        .out_ack  (out_ack_b)
`ifdef MULLER_PIPE_OCC_EN
        ,
        .occupancy(occ_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock; the default-instance producer drops its request as soon as
    // it sees the acknowledge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (in_req_a && in_ack_a) in_req_a = 1'b0;
    endtask

    // Full four-phase send on the default instance; acked=0 if in_ack never rose.
    task automatic send(input logic [7:0] v, input int bound, output bit acked);
        acked     = 1'b0;
        in_data_a = v;
        in_req_a  = 1'b1;
        for (int n = 0; n < bound; n++) begin
            cyc();
            if (!in_req_a) begin
                acked = 1'b1;
                break;
            end
        end
        if (acked) begin
            for (int n = 0; n < bound && in_ack_a; n++) cyc();
            check("send_ack_release", in_ack_a, 0);
        end
    endtask

    logic [15:0] sb [$];
    int          p_phase, p_wait, sent;
    int          c_phase, c_wait, recv;
    logic [15:0] tok;
    logic [15:0] exp_b;
    int          occ_max;

    initial begin
        bit          ok;
        bit          seen;
        int          lat;
        logic [7:0]  exp_tok [3];

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        check("rst_in_ack", in_ack_a, 0);
        check("rst_out_req", out_req_a, 0);
        check("rst_out_data", out_data_a, 0);
`ifdef MULLER_PIPE_OCC_EN
        check("rst_occ", occ_a, 0);
`endif

        // Single token 0xA5, consumer acks follow out_req
        rst       = 1'b0;
        ack_tie   = 1'b1;
        in_data_a = 8'hA5;
        in_req_a  = 1'b1;
        cyc();
        check("t1_in_ack_rise", in_ack_a, 1);
        cyc();
        cyc();
        check("t1_out_req_early", out_req_a, 0);
        cyc();
        check("t1_out_req_lat4", out_req_a, 1);
        check("t1_out_data", out_data_a, 8'hA5);
        for (int n = 0; n < 6; n++) cyc();
        check("t1_out_req_done", out_req_a, 0);
        check("t1_in_ack_done", in_ack_a, 0);

        // Capacity with out_ack held low
        ack_tie = 1'b0;
        ack_drv = 1'b0;
        send(8'h11, 20, ok);
        check("cap_ack_11", ok, 1);
        send(8'h22, 20, ok);
        check("cap_ack_22", ok, 1);
        send(8'h33, 20, ok);
        check("cap_ack_33_blocked", ok, 0);
        check("cap_in_ack", in_ack_a, 0);
        check("cap_out_req", out_req_a, 1);
        check("cap_out_data", out_data_a, 8'h11);
`ifdef MULLER_PIPE_OCC_EN
        check("cap_occ", occ_a, 2);
`endif

        // Drain in FIFO order
        exp_tok = '{8'h11, 8'h22, 8'h33};
        for (int j = 0; j < 3; j++) begin
            seen = 1'b0;
            for (int n = 0; n < 30; n++) begin
                if (out_req_a) begin
                    seen = 1'b1;
                    break;
                end
                cyc();
            end
            check("drain_req_seen", seen, 1);
            check("drain_data", out_data_a, exp_tok[j]);
            ack_drv = 1'b1;
            seen    = 1'b0;
            for (int n = 0; n < 30; n++) begin
                cyc();
                if (!out_req_a) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("drain_req_fall", seen, 1);
            ack_drv = 1'b0;
        end
        for (int n = 0; n < 10; n++) cyc();
        check("drain_out_req_idle", out_req_a, 0);
        check("drain_in_ack_idle", in_ack_a, 0);
`ifdef MULLER_PIPE_OCC_EN
        check("drain_occ", occ_a, 0);
`endif

        // Reset while two tokens are held
        send(8'h77, 20, ok);
        check("mid_ack_77", ok, 1);
        send(8'h88, 20, ok);
        check("mid_ack_88", ok, 1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mrst_in_ack", in_ack_a, 0);
        check("mrst_out_req", out_req_a, 0);
        check("mrst_out_data", out_data_a, 0);
`ifdef MULLER_PIPE_OCC_EN
        check("mrst_occ", occ_a, 0);
`endif
        ack_tie   = 1'b1;
        in_data_a = 8'h5A;
        in_req_a  = 1'b1;
        lat       = 0;
        seen      = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            if (out_req_a) begin
                lat  = n;
                seen = 1'b1;
                break;
            end
        end
        check("post_rst_seen", seen, 1);
        check("post_rst_latency", lat, 4);
        check("post_rst_data", out_data_a, 8'h5A);
        for (int n = 0; n < 8; n++) cyc();

        // Randomized four-phase run, 1000 tokens, DEPTH=6
        p_phase = 0; p_wait = 0; sent = 0;
        c_phase = 0; c_wait = 0; recv = 0;
        occ_max = 0;
        for (int n = 0; n < 60000; n++) begin
            if (recv == 1000) break;
            @(posedge clk);
            #1;
`ifdef MULLER_PIPE_OCC_EN
            if (int'(occ_b) > occ_max) occ_max = int'(occ_b);
`endif
            case (p_phase)
                0: begin
                    if (p_wait > 0) p_wait--;
                    else if (sent < 1000) begin
                        tok       = 16'($urandom_range(0, 65535));
                        in_data_b = tok;
                        in_req_b  = 1'b1;
                        sb.push_back(tok);
                        sent++;
                        p_phase = 1;
                    end
                end
                1: if (in_ack_b) begin
                    in_req_b = 1'b0;
                    p_phase  = 2;
                end
                default: if (!in_ack_b) begin
                    p_wait  = int'($urandom_range(0, 3));
                    p_phase = 0;
                end
            endcase
            case (c_phase)
                0: if (out_req_b) begin
                    c_wait  = int'($urandom_range(0, 4));
                    c_phase = 1;
                end
                1: begin
                    if (c_wait > 0) c_wait--;
                    else begin
                        if (sb.size() == 0) begin
                            check("rnd_unexpected_token", out_data_b, 16'hxxxx);
                        end else begin
                            exp_b = sb.pop_front();
                            check("rnd_data", out_data_b, exp_b);
                        end
                        out_ack_b = 1'b1;
                        recv++;
                        c_phase = 2;
                    end
                end
                default: if (!out_req_b) begin
                    out_ack_b = 1'b0;
                    c_phase   = 0;
                end
            endcase
        end
        check("rnd_recv_count", recv, 1000);
        check("rnd_sb_empty", sb.size(), 0);
`ifdef MULLER_PIPE_OCC_EN
        check("rnd_occ_max_le3", occ_max <= 3, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
